// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared defaults and the next-PC source select type for the
//                program-counter unit and its return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Default geometry: 16-bit PC, 2-byte instructions, 4-entry RAS
    localparam int unsigned c_DEF_WIDTH     = 16;
    localparam int unsigned c_DEF_INC       = 2;
    localparam int unsigned c_DEF_RAS_DEPTH = 4;

    // Which source feeds the PC register on the next edge
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        REDIR = 2'd1,
        RET   = 2'd2,
        SEQ   = 2'd3
    } npc_src_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular LIFO return-address stack. A push when full
//                overwrites the oldest entry and the count saturates. A pop
//                on an empty stack is ignored. Push wins if both are raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned DEPTH = c_DEF_RAS_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_push_data,
    output logic [WIDTH-1:0]         o_top,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    // The write pointer always names the next free slot; when full that slot
    // holds the oldest entry, so a push there gives the circular overwrite.
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_CNT_W-1:0] r_count_q,  w_count_d;
    logic [c_PTR_W-1:0] w_top_idx;
    logic [WIDTH-1:0]   r_mem_q [DEPTH];

    assign w_top_idx = r_wr_ptr_q - c_PTR_W'(1);
    assign o_top     = r_mem_q[w_top_idx];
    assign o_count   = r_count_q;
    assign o_full    = (r_count_q == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count_q == '0);

    // Next pointer/count from push or pop
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_count_d  = r_count_q;
        if (i_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
            if (!o_full) begin
                w_count_d = r_count_q + c_CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            w_wr_ptr_d = w_top_idx;
            w_count_d  = r_count_q - c_CNT_W'(1);
        end
    end

    // Pointer and count registers; reset discards all entries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Entry storage; contents are left as-is on reset
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_q[r_wr_ptr_q] <= i_push_data;
        end
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Registered program counter with stall, redirect, call/return
//                via a return-address stack, and sticky overflow/underflow.
//                Priority: rst > stall > redirect > ret > sequential.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = c_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      INC       = c_DEF_INC,
    parameter int unsigned      RAS_DEPTH = c_DEF_RAS_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [WIDTH-1:0]            redirect_target,
    input  logic                        call,
    input  logic                        ret,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            pc_next_seq,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ras_ovf,
    output logic                        ras_unf
);

    logic [WIDTH-1:0] r_pc_q,  w_pc_d;
    logic             r_ovf_q, w_ovf_d;
    logic             r_unf_q, w_unf_d;
    npc_src_e         w_src;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_ras_top;

    // Sequential address wraps naturally in WIDTH bits
    assign pc_next_seq = r_pc_q + WIDTH'(INC);
    assign pc          = r_pc_q;
    assign ras_ovf     = r_ovf_q;
    assign ras_unf     = r_unf_q;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (pc_next_seq),
        .o_top       (w_ras_top),
        .o_count     (ras_count),
        .o_full      (ras_full),
        .o_empty     (ras_empty)
    );

    // Select next-PC source and derive stack operations and flag updates
    always_comb begin
        w_src   = SEQ;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_ovf_d = r_ovf_q;
        w_unf_d = r_unf_q;
        w_pc_d  = pc_next_seq;
        if (stall) begin
            w_src = HOLD;
        end else if (redirect) begin
            w_src  = REDIR;
            w_push = call;
            if (call && ras_full) begin
                w_ovf_d = 1'b1;
            end
        end else if (ret) begin
            if (ras_empty) begin
                // Nothing to return to: fall through sequentially
                w_src   = SEQ;
                w_unf_d = 1'b1;
            end else begin
                w_src = RET;
                w_pop = 1'b1;
            end
        end
        case (w_src)
            HOLD:    w_pc_d = r_pc_q;
            REDIR:   w_pc_d = redirect_target;
            RET:     w_pc_d = w_ras_top;
            default: w_pc_d = pc_next_seq;
        endcase
    end

    // PC and sticky flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q  <= RESET_VEC;
            r_ovf_q <= 1'b0;
            r_unf_q <= 1'b0;
        end else begin
            r_pc_q  <= w_pc_d;
            r_ovf_q <= w_ovf_d;
            r_unf_q <= w_unf_d;
        end
    end

endmodule : pc_unit
`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16: PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 16'h0000: PC value loaded by reset.
REQ-003 Parameter INC, default 2: sequential increment, the instruction size in bytes.
REQ-004 Parameter RAS_DEPTH, default 4: return-address stack entries; power of 2, at least 2.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port stall, input, 1: hold PC and RAS this cycle.
REQ-008 Port redirect, input, 1: load redirect_target (branch or jump taken).
REQ-009 Port redirect_target, input, WIDTH: redirect destination.
REQ-010 Port call, input, 1: with redirect, push pc+INC onto the RAS.
REQ-011 Port ret, input, 1: load PC from the RAS top and pop.
REQ-012 Port pc, output, WIDTH: current PC, registered.
REQ-013 Port pc_next_seq, output, WIDTH: combinational pc+INC.
REQ-014 Port ras_count, output, clog2(RAS_DEPTH)+1: number of valid entries.
REQ-015 Port ras_empty / ras_full, output, 1 each: ras_count==0 / ras_count==RAS_DEPTH.
REQ-016 Port ras_ovf / ras_unf, output, 1 each: sticky overflow / underflow flags.

Function
REQ-017 pc SHALL change only on a rising clk edge; no combinational path from any input to pc.
REQ-018 Next-PC priority SHALL be rst > stall (hold) > redirect > ret > sequential (pc+INC).
REQ-019 pc+INC SHALL wrap modulo 2^WIDTH (0xFFFE+2 -> 0x0000 at WIDTH=16).
REQ-020 A new pc SHALL be visible one cycle after the inputs are sampled; a redirect has 1-cycle latency.
REQ-021 stall=1 SHALL freeze pc, RAS contents, ras_count and flags, overriding redirect, call and ret.
REQ-022 call=1 with redirect=0 SHALL be ignored (no push).
REQ-023 call=1 with redirect=1 SHALL push pc+INC (wrapped), set pc<=redirect_target and increment ras_count.
REQ-024 A push when full SHALL overwrite the oldest entry (circular), keep ras_count=RAS_DEPTH and set ras_ovf.
REQ-025 ret=1 with redirect=0 and RAS not empty SHALL set pc<=top entry and decrement ras_count.
REQ-026 ret=1 on an empty RAS SHALL set pc<=pc+INC, leave ras_count at 0 and set ras_unf.
REQ-027 ret together with redirect SHALL be ignored: redirect wins and there is no pop; with call also set, the push occurs.
REQ-028 ras_ovf and ras_unf SHALL stay set until reset.

Reset
REQ-029 A cycle with rst=1 SHALL set pc=RESET_VEC, ras_count=0, ras_ovf=0 and ras_unf=0, overriding all other inputs including stall.
REQ-030 A reset asserted mid-sequence SHALL discard all RAS entries; RAM contents need not be cleared.
REQ-031 The first cycle after rst deasserts SHALL present pc=RESET_VEC; the next edge advances it normally.

Structure
REQ-032 A shared package pc_pkg SHALL hold the default WIDTH, INC and RAS_DEPTH constants and a next-PC source enum (HOLD, REDIR, RET, SEQ).
REQ-033 The RAS SHALL be a sub-module ras_stack (circular LIFO with push, pop, top, count and full/empty signals) instantiated once.
REQ-034 All arithmetic SHALL be unsigned WIDTH-bit.

Verification
REQ-035 Reset then 3 free cycles -> pc sequence 0x0000, 0x0002, 0x0004, 0x0006.
REQ-036 At pc=0x0010, redirect=1 with target 0x0100 and stall=1 -> pc holds at 0x0010; after stall drops -> 0x0100 next cycle.
REQ-037 call to 0x0200 from pc=0x0040, then ret -> pc 0x0200, then 0x0042; ras_count goes 1 then 0.
REQ-038 Five nested calls at RAS_DEPTH=4 -> ras_full=1 and ras_ovf=1; four rets return the four newest pc+INC values, newest first.
REQ-039 ret at reset (empty RAS) -> pc=0x0002 and ras_unf=1; rst=1 -> flag clears and pc=0x0000.
REQ-040 Seed pc=0xFFFE via redirect, then one free cycle -> pc=0x0000 (wrap).
